aes_ct_serializer: RTL and testbench

Downstream stage of the AES-128 encryption core. It captures the 128-bit ciphertext when the core's done level rises and streams it out as DATA_W-bit beats over a valid/ready interface, most-significant beat first. A one-block holding buffer lets the block accept a new ciphertext while the current one is still draining. Overrun is flagged when the holding buffer is already full.

---
 rtl/aes_ct_serializer.sv | 122 ++++++++++++
 tb/tb_aes_ct_serializer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_ct_serializer.sv
// Ciphertext serializer: captures a 128-bit AES block on the rising edge of the core's done level and streams it MSB-beat first.
// Latency: first beat is valid one cycle after the capture edge; back-to-back blocks stream with no bubble.
// Backpressure: o_data/o_last/o_valid hold while i_ready is low; a one-block hold buffer absorbs one extra block, beyond that blocks are dropped and o_overrun is set.
module aes_ct_serializer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [127:0]      i_block,
  input  logic              i_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_last,
  output logic              o_busy,
  output logic              o_overrun
);

  localparam int BEATS = 128 / DATA_W;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(BEATS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_valid_q;
  logic [127:0]  r_shift, w_shift_nxt, w_shifted;
  logic [127:0]  r_hold, w_hold_nxt;
  logic          r_hold_full, w_hold_full_nxt;
  logic          r_overrun, w_overrun_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          w_event, w_xfer, w_last_xfer;

  // The core's done level is sticky, so only its rising edge starts a block.
  assign w_event     = i_valid & ~r_valid_q;
  assign w_xfer      = o_valid & i_ready;
  assign w_last_xfer = w_xfer & (r_cnt == LAST_IDX);

  // Beat k is always the top DATA_W bits; a transfer shifts the next beat up.
  if (BEATS > 1) begin : g_shift
    assign w_shifted = {r_shift[127-DATA_W:0], {DATA_W{1'b0}}};
  end else begin : g_noshift
    assign w_shifted = '0;
  end

  assign o_valid   = (r_state == SEND);
  assign o_data    = r_shift[127 -: DATA_W];
  assign o_last    = o_valid & (r_cnt == LAST_IDX);
  assign o_busy    = o_valid | r_hold_full;
  assign o_overrun = r_overrun;

  // Next-state: load, advance, refill from hold or direct input, or drop on overrun.
  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_cnt_nxt       = r_cnt;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
    w_overrun_nxt   = r_overrun;
    case (r_state)
      IDLE: begin
        if (w_event) begin
          w_shift_nxt = i_block;
          w_cnt_nxt   = '0;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (w_last_xfer) begin
          w_cnt_nxt = '0;
          if (r_hold_full) begin
            // Hold frees up this cycle, so a simultaneous new block refills it.
            w_shift_nxt = r_hold;
            if (w_event) w_hold_nxt = i_block;
            else         w_hold_full_nxt = 1'b0;
          end else if (w_event) begin
            w_shift_nxt = i_block;
          end else begin
            w_shift_nxt = '0;
            w_state_nxt = IDLE;
          end
        end else begin
          if (w_xfer) begin
            w_shift_nxt = w_shifted;
            w_cnt_nxt   = r_cnt + CW'(1);
          end
          if (w_event) begin
            if (r_hold_full) begin
              w_overrun_nxt = 1'b1;
            end else begin
              w_hold_nxt      = i_block;
              w_hold_full_nxt = 1'b1;
            end
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_valid_q   <= 1'b0;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_valid_q   <= i_valid;
      r_shift     <= w_shift_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_overrun   <= w_overrun_nxt;
    end
  end

endmodule

// File: tb/tb_aes_ct_serializer.sv
// Bench for aes_ct_serializer: directed tables and sequences plus random traffic on an 8-bit instance,
// with a queue-based beat scoreboard; 32-bit and 128-bit instances cover reset mid-stream and single-beat blocks.
module tb_aes_ct_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [127:0] blk8, blk32, blk128;
  logic v8, v32, v128, r8, r32, r128;
  logic [7:0]   d8;
  logic [31:0]  d32;
  logic [127:0] d128;
  logic vo8, l8, b8, ov8;
  logic vo32, l32, b32, ov32;
  logic vo128, l128, b128, ov128;

  aes_ct_serializer #(.DATA_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .i_block(blk8), .i_valid(v8), .o_data(d8), .o_valid(vo8),
    .i_ready(r8), .o_last(l8), .o_busy(b8), .o_overrun(ov8));
  aes_ct_serializer #(.DATA_W(32)) u_dut32 (
    .clk(clk), .rst(rst), .i_block(blk32), .i_valid(v32), .o_data(d32), .o_valid(vo32),
    .i_ready(r32), .o_last(l32), .o_busy(b32), .o_overrun(ov32));
  aes_ct_serializer #(.DATA_W(128)) u_dut128 (
    .clk(clk), .rst(rst), .i_block(blk128), .i_valid(v128), .o_data(d128), .o_valid(vo128),
    .i_ready(r128), .o_last(l128), .o_busy(b128), .o_overrun(ov128));

  int n_checks = 0;
  int n_fail   = 0;
  int xfer_cnt = 0;

  logic [127:0] blk_a = 128'h3925841d02dc09fbdc118597196a0b32;
  logic [127:0] blk_b = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model for the 8-bit instance: a queue of outstanding beats.
  // A new block is accepted when fewer than two whole blocks remain after this cycle's transfer.
  logic [7:0] mq[$];
  logic m_prev = 1'b0;
  logic m_ovr  = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      m_prev = 1'b0;
      m_ovr  = 1'b0;
    end else begin
      check("mdl_valid", vo8, mq.size() != 0);
      check("mdl_busy", b8, mq.size() != 0);
      check("mdl_overrun", ov8, m_ovr);
      if (mq.size() != 0) begin
        check("mdl_data", d8, mq[0]);
        check("mdl_last", l8, (mq.size() % 16) == 1);
      end
      if (vo8 && r8) xfer_cnt++;
      if (mq.size() != 0 && r8) void'(mq.pop_front());
      if (v8 && !m_prev) begin
        if ((mq.size() + 15) / 16 < 2) begin
          for (int k = 0; k < 16; k++) mq.push_back(blk8[127-8*k -: 8]);
        end else begin
          m_ovr = 1'b1;
        end
      end
      m_prev = v8;
    end
  end

  typedef struct {
    logic       rdy;
    logic       vld;
    logic [7:0] dat;
    logic       lst;
  } vec_t;
  vec_t tab[66];

  task automatic apply_rows(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      tick();
      r8 = tab[i].rdy;
      @(negedge clk);
      check("tab_valid", vo8, tab[i].vld);
      check("tab_busy", b8, tab[i].vld);
      if (tab[i].vld) begin
        check("tab_data", d8, tab[i].dat);
        check("tab_last", l8, tab[i].lst);
      end
    end
  endtask

  // Expects block x then block y, 32 beats with valid every cycle (i_ready already high).
  task automatic drain_two(input string nm, input logic [127:0] x, input logic [127:0] y);
    logic [255:0] both;
    both = {x, y};
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check({nm, "_valid"}, vo8, 1'b1);
      check({nm, "_data"}, d8, both[255-8*i -: 8]);
      check({nm, "_last"}, l8, (i % 16) == 15);
      tick();
    end
    @(negedge clk);
    check({nm, "_idle"}, vo8, 1'b0);
  endtask

  initial begin
    int x0;
    for (int i = 0; i < 18; i++) begin
      tab[i].rdy = 1'b1;
      tab[i].vld = (i < 16);
      tab[i].dat = (i < 16) ? blk_a[127-8*i -: 8] : 8'h00;
      tab[i].lst = (i == 15);
    end
    for (int j = 0; j < 48; j++) begin
      int beat;
      beat = (j + 2) / 3;
      tab[18+j].rdy = (j % 3 == 0);
      tab[18+j].vld = (j <= 45);
      tab[18+j].dat = (j <= 45) ? blk_a[127-8*beat -: 8] : 8'h00;
      tab[18+j].lst = (beat == 15);
    end

    rst = 1'b1;
    v8 = 0; r8 = 0; blk8 = '0;
    v32 = 0; r32 = 0; blk32 = '0;
    v128 = 0; r128 = 0; blk128 = '0;
    repeat (2) tick();
    @(negedge clk);
    check("rst_valid8", vo8, 1'b0);
    check("rst_data8", d8, 8'h00);
    check("rst_last8", l8, 1'b0);
    check("rst_busy8", b8, 1'b0);
    check("rst_ovr8", ov8, 1'b0);
    check("rst_valid32", vo32, 1'b0);
    tick();
    rst = 1'b0;

    // Test 1: single block, free-flowing
    tick();
    x0 = xfer_cnt;
    v8 = 1'b1; blk8 = blk_a; r8 = 1'b1;
    @(negedge clk);
    check("t1_lat_valid", vo8, 1'b0);
    apply_rows(0, 18);

    // Test 2: level held high, exactly one block
    repeat (32) tick();
    @(negedge clk);
    check("t2_xfers", xfer_cnt - x0, 16);
    check("t2_overrun", ov8, 1'b0);
    check("t2_idle", vo8, 1'b0);

    // Test 3: stalls with ready pattern 1,0,0
    tick();
    v8 = 1'b0;
    tick();
    x0 = xfer_cnt;
    v8 = 1'b1; blk8 = blk_a;
    apply_rows(18, 48);
    check("t3_xfers", xfer_cnt - x0, 16);

    // Test 4: second block held while first stalls, then back-to-back
    tick(); v8 = 1'b0;
    tick(); v8 = 1'b1; blk8 = blk_a; r8 = 1'b0;
    tick(); v8 = 1'b0;
    tick(); v8 = 1'b1; blk8 = blk_b;
    tick();
    @(negedge clk);
    check("t4_busy", b8, 1'b1);
    check("t4_hold_data", d8, 8'h39);
    tick(); r8 = 1'b1;
    drain_two("t4", blk_a, blk_b);

    // Test 5: third block while hold is full -> overrun, dropped
    tick(); v8 = 1'b0; r8 = 1'b0;
    tick(); v8 = 1'b1; blk8 = blk_a;
    tick(); v8 = 1'b0;
    tick(); v8 = 1'b1; blk8 = blk_b;
    tick(); v8 = 1'b0;
    tick(); v8 = 1'b1; blk8 = '0;
    tick();
    @(negedge clk);
    check("t5_overrun", ov8, 1'b1);
    tick(); r8 = 1'b1;
    drain_two("t5", blk_a, blk_b);
    repeat (5) tick();
    @(negedge clk);
    check("t5_ovr_sticky", ov8, 1'b1);
    check("t5_no_c", vo8, 1'b0);

    // Random traffic against the scoreboard, with a reset part way through
    tick(); rst = 1'b1; v8 = 1'b0;
    tick(); rst = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      tick();
      rst  = (c == 1000);
      r8   = ($urandom_range(0, 3) != 0);
      blk8 = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 9) == 0) v8 = ~v8;
    end
    tick(); v8 = 1'b0; r8 = 1'b1; rst = 1'b0;
    repeat (40) tick();
    @(negedge clk);
    check("rnd_drained", vo8, 1'b0);

    // Single-beat blocks: every beat is last, hold refills with no bubble
    tick(); v128 = 1'b1; blk128 = blk_a; r128 = 1'b0;
    tick();
    @(negedge clk);
    check("w128_valid", vo128, 1'b1);
    check("w128_last", l128, 1'b1);
    check("w128_data", d128, blk_a);
    tick(); v128 = 1'b0;
    tick(); v128 = 1'b1; blk128 = blk_b;
    tick();
    @(negedge clk);
    check("w128_busy", b128, 1'b1);
    check("w128_stall", d128, blk_a);
    tick(); r128 = 1'b1;
    @(negedge clk);
    check("w128_first", d128, blk_a);
    tick();
    @(negedge clk);
    check("w128_second_valid", vo128, 1'b1);
    check("w128_second", d128, blk_b);
    check("w128_second_last", l128, 1'b1);
    tick();
    @(negedge clk);
    check("w128_idle", vo128, 1'b0);
    check("w128_idle_busy", b128, 1'b0);
    check("w128_ovr", ov128, 1'b0);

    // Test 6: 32-bit beats, reset mid-stream
    tick(); v32 = 1'b1; blk32 = blk_b; r32 = 1'b1;
    tick();
    @(negedge clk);
    check("t6_beat0", d32, 32'h69c4e0d8);
    check("t6_last0", l32, 1'b0);
    tick();
    @(negedge clk);
    check("t6_beat1", d32, 32'h6a7b0430);
    tick();
    check("t6_beat2", d32, 32'hd8cdb780);
    rst = 1'b1;
    v32 = 1'b0;
    #1;
    check("t6_rst_data", d32, 32'h0);
    check("t6_rst_valid", vo32, 1'b0);
    check("t6_rst_last", l32, 1'b0);
    check("t6_rst_busy", b32, 1'b0);
    check("t6_rst_ovr", ov32, 1'b0);
    tick(); rst = 1'b0;
    repeat (5) begin
      tick();
      @(negedge clk);
      check("t6_stay_idle", vo32, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
